// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-level request/status handshake between the core's byte
// producer and the UART transmitter. The producer drives the master modport
// and the transmitter drives the slave modport.
interface uart_tx_if #(
    parameter int NB_DATA = 8
);
    logic               tx_start;   // transmit request, sampled every cycle
    logic [NB_DATA-1:0] tx_data;    // byte to send, captured on the accepting cycle
    logic               tx_busy;    // frame in flight
    logic               tx_done;    // one-cycle pulse at frame completion

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter, 8N1 by default (start bit, NB_DATA data
// bits LSB first, stop bit) with an internal baud counter of CLKS_PER_BIT
// clocks per bit. No FIFO; back-pressure is signalled through tx_busy.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between
// the data bits and the stop bit (8E1, 11 bit periods per frame).
// Every output comes straight from a flop; there is no input-to-output
// combinational path.
module uart_tx #(
    parameter int NB_DATA      = 8,
    parameter int CLKS_PER_BIT = 2604
) (
    input  logic     i_clock,
    input  logic     i_reset,
    uart_tx_if.slave bus,
    output logic     o_tx
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_DATA - 1);

    // One-hot state encoding; anything else is treated as illegal.
`ifdef UART_TX_PARITY_EN
    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;
`endif

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   clk_cnt;
    logic [CNT_W-1:0]   clk_cnt_next;
    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_next;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] shreg_next;
    logic               tx_q;
    logic               tx_next;
    logic               busy_q;
    logic               busy_next;
    logic               done_q;
    logic               done_next;
    logic               bit_end;

    // Last clock of the current bit period.
    assign bit_end = (clk_cnt == CNT_LAST);

    assign o_tx        = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

    // Next-state and next-output decode; the line value for the upcoming bit
    // is computed here so that o_tx changes on the same edge as the state.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt + CNT_W'(1);
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        tx_next      = tx_q;
        busy_next    = busy_q;
        done_next    = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_next = '0;
                tx_next      = 1'b1;
                busy_next    = 1'b0;
                if (bus.tx_start) begin
                    state_next = START;
                    shreg_next = bus.tx_data;
                    tx_next    = 1'b0;
                    busy_next  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    tx_next      = shreg[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    clk_cnt_next = '0;
                    // Wraps back to zero after the last data bit.
                    bit_idx_next = bit_idx + IDX_W'(1);
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = ^shreg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        tx_next = shreg[bit_idx + IDX_W'(1)];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next   = STOP;
                    clk_cnt_next = '0;
                    tx_next      = 1'b1;
                end
            end
`endif

            STOP: begin
                if (bit_end) begin
                    state_next   = IDLE;
                    clk_cnt_next = '0;
                    tx_next      = 1'b1;
                    busy_next    = 1'b0;
                    done_next    = 1'b1;
                end
            end

            default: begin
                // Illegal encoding: recover to an idle, high line.
                state_next   = IDLE;
                clk_cnt_next = '0;
                bit_idx_next = '0;
                tx_next      = 1'b1;
                busy_next    = 1'b0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs; reset wins over
    // everything and drops any frame in flight without a done pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_idx <= bit_idx_next;
            shreg   <= shreg_next;
            tx_q    <= tx_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
        end
    end

endmodule
